// File: rtl/bb_shift_accumulator.sv
// bb_shift_accumulator: weights bit-blade partial sums by 4^(i+j)
// and accumulates 16 beats into one signed dot product.
module bb_shift_accumulator #(
  parameter int PSUM_W    = 10,
  parameter int ACC_W     = 20,
  parameter int NUM_BLADE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic [3:0]        step
);

  localparam int BW   = $clog2(NUM_BLADE);
  localparam int LAST = NUM_BLADE * NUM_BLADE - 1;

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   result_d;
  logic [3:0]         step_d;
  logic [BW:0]        blade_sum;
  logic [BW+1:0]      shamt;
  logic [ACC_W-1:0]   psum_ext;
  logic [ACC_W-1:0]   term;
  logic               accept;

  // Blade-pair weight: shift by 2*(i+j), i and j taken from the step index.
  always_comb begin
    blade_sum = {1'b0, step[2*BW-1:BW]} + {1'b0, step[BW-1:0]};
    shamt     = {blade_sum, 1'b0};
    psum_ext  = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
    term      = psum_ext << shamt;
    accept    = in_valid & in_ready;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      result  <= '0;
      step    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      result  <= result_d;
      step    <= step_d;
    end
  end

  // Next-state: accumulate, close a group, drain or abandon.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result;
    step_d   = step;
    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      step_d  = '0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (step == 4'(LAST)) begin
              result_d = acc_q + term;
              acc_d    = '0;
              step_d   = '0;
              state_d  = ST_DONE;
            end else begin
              acc_d  = acc_q + term;
              step_d = step + 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACC;
            if (accept) begin
              acc_d  = term;
              step_d = 4'd1;
            end
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    out_valid = (state_q == ST_DONE);
    in_ready  = (state_q == ST_ACC) | out_ready;
  end

endmodule
